// File: rtl/lvds_data_write.sv
// lvds_data_write: AXI-lite slave that holds a frame of up to 128 32-bit
// words and serializes it onto 4 LVDS lanes with a forwarded bit clock.
// Buffer at offsets 0x000-0x1FC, CTRL 0x200, LENGTH 0x204, STATUS 0x208.
module lvds_data_write #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR         = 32'h0000_0000,
  parameter logic [31:0] C_S_AXI_MIN_SIZE   = 32'h0000_03FF,
  parameter int unsigned BUFFER_WORDS       = 128,
  parameter int unsigned C_CLK_DIV          = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [3:0]                      LVDS_OUT,
  output logic                            LVDS_CLK_OUT,
  output logic                            LED0
);

  localparam int unsigned IDX_W    = $clog2(BUFFER_WORDS);
  localparam int unsigned DIV_W    = $clog2(C_CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(C_CLK_DIV / 2);
  localparam logic [7:0] LEN_MAX   = 8'(BUFFER_WORDS);
  localparam logic [9:0] OFF_MASK  = C_S_AXI_MIN_SIZE[9:0];
  // Base above high (the unconfigured default) disables the window check.
  localparam bit WIN_CHECK         = (C_BASEADDR <= C_HIGHADDR);

  localparam logic [7:0] SEL_CTRL   = 8'h80;
  localparam logic [7:0] SEL_LEN    = 8'h81;
  localparam logic [7:0] SEL_STATUS = 8'h82;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  function automatic logic in_window(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return !WIN_CHECK || ((a32 >= C_BASEADDR) && (a32 <= C_HIGHADDR));
  endfunction

  logic [31:0] mem [BUFFER_WORDS];

  state_t           state_q;
  logic             busy_q, done_q, cont_q;
  logic [7:0]       len_q;
  logic [31:0]      shreg_q, pf_q;
  logic [3:0]       out_q;
  logic             lclk_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       nib_q;
  logic [IDX_W-1:0] widx_q;

  logic             awready_q, bvalid_q;
  logic [1:0]       bresp_q;
  logic             arready_q, rvalid_q;
  logic [31:0]      rdata_q;

  // Write-side decode
  logic       wr_hs, aw_in_win;
  logic [7:0] aw_sel;
  logic       aw_is_buf, aw_is_ctrl, aw_is_len, aw_is_status;
  logic       ctrl_start, ctrl_abort;

  assign wr_hs        = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign aw_in_win    = in_window(S_AXI_AWADDR);
  assign aw_sel       = S_AXI_AWADDR[9:2] & OFF_MASK[9:2];
  assign aw_is_buf    = aw_in_win & ~aw_sel[7];
  assign aw_is_ctrl   = aw_in_win & (aw_sel == SEL_CTRL);
  assign aw_is_len    = aw_in_win & (aw_sel == SEL_LEN);
  assign aw_is_status = aw_in_win & (aw_sel == SEL_STATUS);
  assign ctrl_start   = wr_hs & aw_is_ctrl & S_AXI_WDATA[0];
  assign ctrl_abort   = wr_hs & aw_is_ctrl & S_AXI_WDATA[2];

  // Read-side decode
  logic       ar_hs, ar_in_win;
  logic [7:0] ar_sel;
  logic [31:0] rd_mux;

  assign ar_hs     = arready_q & S_AXI_ARVALID;
  assign ar_in_win = in_window(S_AXI_ARADDR);
  assign ar_sel    = S_AXI_ARADDR[9:2] & OFF_MASK[9:2];

  // Serializer helpers
  logic             last_word;
  logic [IDX_W-1:0] next_idx;
  logic [DIV_W-1:0] div_inc;

  assign last_word = ({1'b0, widx_q} >= (len_q - 8'd1));
  assign next_idx  = last_word ? '0 : widx_q + IDX_W'(1);
  assign div_inc   = div_q + DIV_W'(1);

  logic unused_wstrb;
  assign unused_wstrb = ^S_AXI_WSTRB;

  // Write address/data acceptance and response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (aw_is_buf & busy_q) ? 2'b10 : 2'b00;
      end else if (bvalid_q & S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Frame buffer writes, locked out while a transfer is running
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_hs & aw_is_buf & ~busy_q) begin
      mem[aw_sel[IDX_W-1:0]] <= S_AXI_WDATA;
    end
  end

  // Read data selection
  always_comb begin
    rd_mux = '0;
    if (ar_in_win) begin
      if (!ar_sel[7]) begin
        rd_mux = mem[ar_sel[IDX_W-1:0]];
      end else begin
        case (ar_sel)
          SEL_CTRL:   rd_mux = {30'b0, cont_q, 1'b0};
          SEL_LEN:    rd_mux = {24'b0, len_q};
          SEL_STATUS: rd_mux = {30'b0, done_q, busy_q};
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  // Read address acceptance and registered read data
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q & S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Prefetch of the following word so word boundaries carry no gap
  always_ff @(posedge S_AXI_ACLK) begin
    pf_q <= mem[next_idx];
  end

  // Control registers and serializer FSM with registered lane outputs
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cont_q  <= 1'b0;
      len_q   <= LEN_MAX;
      shreg_q <= '0;
      out_q   <= '0;
      lclk_q  <= 1'b0;
      div_q   <= '0;
      nib_q   <= '0;
      widx_q  <= '0;
    end else begin
      if (wr_hs & aw_is_len) begin
        len_q <= ((S_AXI_WDATA[7:0] == 8'd0) || (S_AXI_WDATA[7:0] > LEN_MAX))
                 ? LEN_MAX : S_AXI_WDATA[7:0];
      end
      if (wr_hs & aw_is_ctrl) begin
        cont_q <= S_AXI_WDATA[1];
      end
      if (wr_hs & aw_is_status & S_AXI_WDATA[1]) begin
        done_q <= 1'b0;
      end

      if (ctrl_abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        out_q   <= '0;
        lclk_q  <= 1'b0;
      end else if (ctrl_start && (state_q == S_IDLE)) begin
        state_q <= S_LOAD;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        widx_q  <= '0;
      end else begin
        case (state_q)
          S_LOAD: begin
            shreg_q <= mem[0];
            out_q   <= mem[0][3:0];
            lclk_q  <= 1'b0;
            div_q   <= '0;
            nib_q   <= '0;
            state_q <= S_SHIFT;
          end
          S_SHIFT: begin
            if (div_q == DIV_LAST) begin
              div_q  <= '0;
              lclk_q <= 1'b0;
              if (nib_q == 3'd7) begin
                nib_q <= '0;
                if (last_word && !cont_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  out_q   <= '0;
                end else begin
                  shreg_q <= pf_q;
                  out_q   <= pf_q[3:0];
                  widx_q  <= next_idx;
                end
              end else begin
                nib_q   <= nib_q + 3'd1;
                shreg_q <= {4'b0, shreg_q[31:4]};
                out_q   <= shreg_q[7:4];
              end
            end else begin
              div_q  <= div_inc;
              lclk_q <= (div_inc >= DIV_HALF);
            end
          end
          default: begin
            out_q  <= '0;
            lclk_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign LVDS_OUT      = out_q;
  assign LVDS_CLK_OUT  = lclk_q;
  assign LED0          = busy_q;

endmodule

// File: tb/tb_lvds_data_write.sv
// Scoreboard bench for lvds_data_write: expected AXI responses and lane
// nibbles are queued by the stimulus; monitors pop and compare.
module tb_lvds_data_write;
  localparam int DIV = 2;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESET;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [3:0]  LVDS_OUT;
  logic        LVDS_CLK_OUT;
  logic        LED0;

  lvds_data_write #(.C_CLK_DIV(DIV)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .LVDS_OUT(LVDS_OUT),
    .LVDS_CLK_OUT(LVDS_CLK_OUT), .LED0(LED0)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int tests = 0;
  int failed = 0;

  logic [31:0] exp_r[$];
  string       exp_rn[$];
  logic [1:0]  exp_b[$];
  logic [3:0]  exp_nib[$];
  bit          nib_strict = 1'b1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    tests++;
    failed++;
    $display("FAIL %s: unexpected event or expired wait", name);
  endfunction

  // Read response monitor
  always @(negedge S_AXI_ACLK) begin
    if (!S_AXI_ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_r.size() != 0) begin
        check(exp_rn.pop_front(), S_AXI_RDATA, exp_r.pop_front());
        check("rresp", 32'(S_AXI_RRESP), 32'h0);
      end else begin
        fail_evt("r_extra");
      end
    end
  end

  // Write response monitor
  always @(negedge S_AXI_ACLK) begin
    if (!S_AXI_ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
      if (exp_b.size() != 0) check("bresp", 32'(S_AXI_BRESP), 32'(exp_b.pop_front()));
      else fail_evt("b_extra");
    end
  end

  // Model receiver: captures a nibble on each rising forwarded clock
  int  negcnt = 0;
  int  last_rise = 0;
  bit  have_prev = 1'b0;
  logic prev_lclk = 1'b0;
  always @(negedge S_AXI_ACLK) begin
    negcnt++;
    if (LVDS_CLK_OUT && !prev_lclk) begin
      if (exp_nib.size() != 0) check("nibble", 32'(LVDS_OUT), 32'(exp_nib.pop_front()));
      else if (nib_strict) fail_evt("nibble_extra");
      if (have_prev && nib_strict) check("nib_spacing", 32'(negcnt - last_rise), 32'(DIV));
      have_prev = 1'b1;
      last_rise = negcnt;
    end
    if (!LED0) have_prev = 1'b0;
    prev_lclk = LVDS_CLK_OUT;
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br);
    bit ok = 1'b0;
    exp_b.push_back(br);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge S_AXI_ACLK);
      if (S_AXI_AWREADY) begin ok = 1'b1; break; end
    end
    if (ok) check("wready_pair", 32'(S_AXI_WREADY), 32'h1);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (!ok) begin fail_evt("aw_timeout"); void'(exp_b.pop_back()); end
  endtask

  task automatic wait_r_drain();
    for (int i = 0; i < 50 && exp_r.size() != 0; i++) @(posedge S_AXI_ACLK);
    #1;
    if (exp_r.size() != 0) begin
      fail_evt("r_timeout");
      exp_r.delete(); exp_rn.delete();
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] e, input string n, input int hold);
    bit ok = 1'b0;
    exp_r.push_back(e); exp_rn.push_back(n);
    if (hold > 0) S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge S_AXI_ACLK);
      if (S_AXI_ARREADY) begin ok = 1'b1; break; end
    end
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    if (!ok) begin fail_evt("ar_timeout"); void'(exp_r.pop_back()); void'(exp_rn.pop_back()); end
    if (hold > 0) begin
      if (ok) for (int k = 0; k < hold; k++) begin
        @(negedge S_AXI_ACLK);
        check("rvalid_hold", 32'(S_AXI_RVALID), 32'h1);
      end
      @(posedge S_AXI_ACLK); #1;
      S_AXI_RREADY = 1'b1;
    end
    wait_r_drain();
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge S_AXI_ACLK); n++;
      if (!LED0) break;
    end
    if (LED0) fail_evt("idle_timeout");
    @(posedge S_AXI_ACLK); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 8; k++) begin
      exp_nib.push_back(t[3:0]);
      t = t >> 4;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] w;
    S_AXI_ARESET = 1'b1; S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0;
    S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    repeat (3) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    check("reset_outs", {24'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                         S_AXI_RVALID, LED0, LVDS_CLK_OUT, |LVDS_OUT}, 32'h0);
    check("reset_rdata", S_AXI_RDATA, 32'h0);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARESET = 1'b0;

    // Reset register values, idle lanes
    axi_read(32'h208, 32'h0, "status_reset", 0);
    axi_read(32'h204, 32'h80, "length_reset", 0);
    axi_read(32'h200, 32'h0, "ctrl_reset", 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge S_AXI_ACLK);
      check("idle_lanes", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h0);
    end
    @(posedge S_AXI_ACLK); #1;

    // Two-word pass: nibbles 0..F with exact start/end timing
    axi_write(32'h000, 32'h7654_3210, 2'b00);
    axi_write(32'h004, 32'hFEDC_BA98, 2'b00);
    axi_write(32'h014, 32'hA5A5_0005, 2'b00);
    axi_write(32'h204, 32'd2, 2'b00);
    push_word(32'h7654_3210); push_word(32'hFEDC_BA98);
    axi_write(32'h200, 32'h1, 2'b00);
    @(negedge S_AXI_ACLK);
    check("busy_after_start", 32'(LED0), 32'h1);
    check("lanes_load", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h00);
    @(negedge S_AXI_ACLK);
    check("first_nib_low", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h00);
    @(negedge S_AXI_ACLK);
    check("first_nib_high", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h10);
    @(negedge S_AXI_ACLK);
    check("second_nib", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h01);
    n = 4;
    for (int i = 0; i < 200; i++) begin
      @(negedge S_AXI_ACLK); n++;
      if (!LED0) break;
    end
    check("busy_length", 32'(n), 32'(2 + 16 * DIV));
    @(posedge S_AXI_ACLK); #1;
    check("nib_left", 32'(exp_nib.size()), 32'h0);
    axi_read(32'h208, 32'h2, "status_done", 0);

    // Buffer access while busy
    push_word(32'h7654_3210); push_word(32'hFEDC_BA98);
    axi_write(32'h200, 32'h1, 2'b00);
    axi_write(32'h014, 32'hDEAD_BEEF, 2'b10);
    axi_read(32'h208, 32'h1, "status_busy", 0);
    axi_read(32'h014, 32'hA5A5_0005, "buf5_busy", 3);
    wait_idle(200, n);
    check("nib_left", 32'(exp_nib.size()), 32'h0);
    axi_read(32'h014, 32'hA5A5_0005, "buf5_after", 0);

    // Continuous mode, stop at the end of the third pass
    axi_write(32'h204, 32'd1, 2'b00);
    for (int p = 0; p < 3; p++) push_word(32'h7654_3210);
    axi_write(32'h200, 32'h3, 2'b00);
    repeat (37) @(posedge S_AXI_ACLK);
    #1;
    axi_write(32'h200, 32'h0, 2'b00);
    wait_idle(200, n);
    check("nib_left_cont", 32'(exp_nib.size()), 32'h0);
    axi_read(32'h208, 32'h2, "status_cont_done", 0);

    // Abort mid-word
    nib_strict = 1'b0;
    axi_write(32'h204, 32'd2, 2'b00);
    axi_write(32'h200, 32'h1, 2'b00);
    repeat (7) @(posedge S_AXI_ACLK);
    #1;
    axi_write(32'h200, 32'h4, 2'b00);
    @(negedge S_AXI_ACLK);
    check("abort_led", 32'(LED0), 32'h0);
    check("abort_lanes", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge S_AXI_ACLK);
      check("abort_quiet", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h0);
    end
    @(posedge S_AXI_ACLK); #1;
    axi_read(32'h208, 32'h0, "status_abort", 0);

    // Reset mid-word
    axi_write(32'h204, 32'd5, 2'b00);
    axi_write(32'h200, 32'h3, 2'b00);
    repeat (9) @(posedge S_AXI_ACLK);
    #1;
    S_AXI_ARESET = 1'b1;
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARESET = 1'b0;
    @(negedge S_AXI_ACLK);
    check("rst_led", 32'(LED0), 32'h0);
    check("rst_lanes", {27'b0, LVDS_CLK_OUT, LVDS_OUT}, 32'h0);
    @(posedge S_AXI_ACLK); #1;
    axi_read(32'h204, 32'h80, "length_after_rst", 0);
    axi_read(32'h208, 32'h0, "status_after_rst", 0);
    axi_read(32'h200, 32'h0, "ctrl_after_rst", 0);
    exp_nib.delete();
    nib_strict = 1'b1;

    // LENGTH clamping and unmapped offsets
    axi_write(32'h204, 32'd0, 2'b00);
    axi_read(32'h204, 32'h80, "length_zero", 0);
    axi_write(32'h204, 32'd200, 2'b00);
    axi_read(32'h204, 32'h80, "length_200", 0);
    axi_write(32'h204, 32'd7, 2'b00);
    axi_read(32'h204, 32'h7, "length_7", 0);
    axi_write(32'h20C, 32'h1234_5678, 2'b00);
    axi_read(32'h20C, 32'h0, "unmapped", 0);

    // Full 128-word pass of incrementing bytes
    for (int i = 0; i < 128; i++) begin
      w = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
      axi_write(32'(i * 4), w, 2'b00);
      push_word(w);
    end
    axi_write(32'h204, 32'd128, 2'b00);
    axi_write(32'h200, 32'h1, 2'b00);
    wait_idle(3000, n);
    check("nib_left_full", 32'(exp_nib.size()), 32'h0);
    axi_read(32'h1FC, {8'd130, 8'd129, 8'd128, 8'd127}, "buf127", 0);
    axi_read(32'h208, 32'h2, "status_full_done", 0);

    repeat (4) @(posedge S_AXI_ACLK);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lvds_data_write.md
Name: lvds_data_write

Overview:
- AXI-lite slave transmitter that feeds the LVDS capture path from the other end of the link.
- CPU writes a 4096-bit frame (128 x 32-bit words) into an internal buffer, then writes START.
- The block serializes the buffer onto 4 LVDS data lanes plus a forwarded clock. It is the source driving a data_read receiver in loopback and board-to-board tests.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_BASEADDR, 32'hFFFF_FFFF, base address of the slave window
C_HIGHADDR, 32'h0000_0000, high address of the slave window
C_S_AXI_MIN_SIZE, 32'h3FF, window size: buffer 0x000-0x1FC, registers 0x200-0x208
BUFFER_WORDS, 128, buffer depth in 32-bit words (4096 bits)
C_CLK_DIV, 2, S_AXI_ACLK cycles per lane bit period; even, >=2

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESET  in  1  reset, synchronous, active-high
S_AXI_AWADDR  in  32  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes (ignored; full-word writes)
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  32  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response (always OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
LVDS_OUT  out  4  serialized data lanes
LVDS_CLK_OUT  out  1  forwarded bit clock
LED0  out  1  high while BUSY

Behaviour:
- Reset: all outputs 0. State IDLE. CTRL=0, LENGTH=128, DONE=0. Buffer contents undefined.
- AXI write channel:
  - Accepted only when AWVALID&WVALID are both high and BVALID=0. AWREADY and WREADY pulse together for 1 cycle.
  - BVALID rises the next cycle and holds until BREADY.
- Write decode on ADDR[9:2] (offset from C_BASEADDR):
  - ADDR[9]=0: buffer word ADDR[8:2].
  - 0x200 CTRL: bit0 START (self-clearing), bit1 CONTINUOUS, bit2 ABORT (self-clearing).
  - 0x204 LENGTH: bits[7:0] = words per pass. 0 or >128 is stored as 128.
  - 0x208 STATUS: write 1 to bit1 clears DONE.
- Write responses:
  - Buffer write while BUSY: dropped, BRESP=SLVERR (2'b10).
  - All other writes: BRESP=OKAY.
  - Unmapped offsets: ignored, BRESP=OKAY.
- AXI read channel:
  - ARREADY pulses 1 cycle when ARVALID=1 and RVALID=0.
  - RVALID and RDATA follow 1 cycle later and hold until RREADY.
  - Buffer reads return stored data. STATUS = {30'b0, DONE, BUSY}. CTRL reads bit1 only. Unmapped offsets read 0.
  - Buffer reads are allowed while BUSY.
- Serializer FSM states: IDLE, LOAD, SHIFT.
  - IDLE -> LOAD on START write (ignored if BUSY). DONE clears and BUSY=1 the cycle after the AW/W handshake.
  - LOAD (1 cycle): registered buffer read of word 0.
  - SHIFT: word is sent as 8 nibbles, LSB nibble first. Each nibble is held C_CLK_DIV cycles.
  - LVDS_CLK_OUT is low for the first C_CLK_DIV/2 cycles of each nibble and high for the rest. The receiver samples on the rising edge.
  - First nibble appears on LVDS_OUT 2 cycles after the START handshake.
  - The next word is prefetched during SHIFT, so there is no gap between words. The clock runs continuously while BUSY.
  - After the last nibble of word LENGTH-1:
    - CONTINUOUS=1: wrap to word 0 gaplessly.
    - CONTINUOUS=0: go to IDLE, BUSY=0, DONE=1.
  - Clearing CONTINUOUS mid-pass stops at the end of the current pass.
- ABORT, or START while BUSY:
  - ABORT: next cycle -> IDLE, LVDS_OUT=0, LVDS_CLK_OUT=0, BUSY=0, DONE unchanged.
  - START while BUSY: ignored.
- Idle lanes: LVDS_OUT=0, LVDS_CLK_OUT=0.
- Reset mid-transfer: immediate return to reset values on the next edge. No trailing nibbles.
- Simultaneous read and write in the same cycle: both handshakes proceed independently.

Test Plan:
- Reset, then read 0x208 -> RDATA=0, RRESP=0. LVDS_OUT=0 and LVDS_CLK_OUT=0 held.
- Write buffer[0]=0x76543210, buffer[1]=0xFEDCBA98, LENGTH=2, START; C_CLK_DIV=2 -> lanes 0..F in order, one nibble per 2 cycles, gapless. First nibble 2 cycles after handshake. DONE=1, BUSY=0 after 16 nibbles.
- Write buffer[5] while BUSY -> BRESP=2'b10, buffer[5] unchanged on readback. Read buffer[5] while BUSY -> correct data, RVALID held until RREADY.
- CONTINUOUS=1, LENGTH=1, START -> 8-nibble pattern repeats 3 times. Clear CONTINUOUS -> transfer ends exactly at the pass boundary, DONE=1.
- ABORT mid-word -> outputs 0 next cycle, BUSY=0, DONE=0. Repeat with S_AXI_ARESET mid-word -> same outputs, LENGTH reads back 128.
- LENGTH=0 write -> reads back 128. Full 128-word pass of incrementing data captured by a model receiver matches the buffer bit-exactly.
